// File: rtl/key_loader_pkg.sv
// Shared types and default sizing for the key loader.
// Holds the FSM state encoding and the default key width / ack timeout.
package key_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        CHECK = 3'd2,
        VALID = 3'd3,
        ERROR = 3'd4
    } state_t;

    localparam int DEFAULT_KEY_WIDTH = 2;
    localparam int DEFAULT_TIMEOUT   = 16;

endpackage

// File: rtl/key_loader_if.sv
// Control, serial key-storage and key-bus signals of the key loader.
// The master modport is the loader; the slave modport is its environment.
interface key_loader_if #(
    parameter int KEY_WIDTH = key_loader_pkg::DEFAULT_KEY_WIDTH
);
    logic                 load_start;
    logic                 nvm_req;
    logic                 nvm_ack;
    logic                 nvm_bit;
    logic [KEY_WIDTH-1:0] key;
    logic                 key_valid;
    logic                 key_error;
    logic                 busy;

    modport master (
        input  load_start,
        input  nvm_ack,
        input  nvm_bit,
        output nvm_req,
        output key,
        output key_valid,
        output key_error,
        output busy
    );

    modport slave (
        output load_start,
        output nvm_ack,
        output nvm_bit,
        input  nvm_req,
        input  key,
        input  key_valid,
        input  key_error,
        input  busy
    );
endinterface

// File: rtl/key_loader_timer.sv
// Per-bit ack wait counter for the key loader.
// expired looks ahead: it fires in the wait cycle whose edge brings the count to TIMEOUT.
module key_loader_timer
    import key_loader_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != CNT_W'(TIMEOUT))) begin
            count_next = count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign expired = inc && !clr && (count_reg == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/key_loader.sv
// Fetches a serial key (LSB first) plus an even-parity bit from key storage,
// then publishes the key only when parity checks; flags parity or ack timeout errors.
module key_loader
    import key_loader_pkg::*;
#(
    parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst,
    key_loader_if.master bus
);
    localparam int BIT_W = $clog2(KEY_WIDTH + 1);

    state_t               state_reg;
    state_t               state_next;
    logic [BIT_W-1:0]     bit_cnt_reg;
    logic [BIT_W-1:0]     bit_cnt_next;
    logic [KEY_WIDTH-1:0] shadow_reg;
    logic [KEY_WIDTH-1:0] shadow_next;
    logic                 parity_reg;
    logic                 parity_next;
    logic [KEY_WIDTH-1:0] key_reg;
    logic [KEY_WIDTH-1:0] key_next;

    logic fetching;
    logic transfer;
    logic last_bit;
    logic enter_fetch;
    logic parity_ok;
    logic timer_clr;
    logic timer_inc;
    logic timer_expired;

    assign fetching  = (state_reg == FETCH);
    assign transfer  = fetching && bus.nvm_ack;
    assign last_bit  = (bit_cnt_reg == BIT_W'(KEY_WIDTH));
    assign parity_ok = ~((^shadow_reg) ^ parity_reg);
    assign timer_clr = enter_fetch || transfer;
    assign timer_inc = fetching && !bus.nvm_ack;

    key_loader_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .inc    (timer_inc),
        .expired(timer_expired)
    );

    // load_start is only honoured outside FETCH/CHECK, so a busy load cannot restart.
    always_comb begin
        state_next  = state_reg;
        enter_fetch = 1'b0;
        case (state_reg)
            IDLE, VALID, ERROR: begin
                if (bus.load_start) begin
                    state_next  = FETCH;
                    enter_fetch = 1'b1;
                end
            end
            FETCH: begin
                if (transfer && last_bit) begin
                    state_next = CHECK;
                end else if (timer_expired) begin
                    state_next = ERROR;
                end
            end
            CHECK: begin
                state_next = parity_ok ? VALID : ERROR;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        parity_next  = parity_reg;
        key_next     = key_reg;
        if (enter_fetch) begin
            bit_cnt_next = '0;
            parity_next  = 1'b0;
            key_next     = '0;
        end else if (transfer) begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            if (last_bit) begin
                parity_next = bus.nvm_bit;
            end
        end
        if ((state_reg == CHECK) && parity_ok) begin
            key_next = shadow_reg;
        end
    end

    // Each shadow bit captures the transfer whose index matches its position.
    generate
        for (genvar gi = 0; gi < KEY_WIDTH; gi++) begin : g_shadow
            assign shadow_next[gi] = enter_fetch ? 1'b0 :
                                     (transfer && (bit_cnt_reg == BIT_W'(gi))) ? bus.nvm_bit :
                                     shadow_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            shadow_reg  <= '0;
            parity_reg  <= 1'b0;
            key_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shadow_reg  <= shadow_next;
            parity_reg  <= parity_next;
            key_reg     <= key_next;
        end
    end

    assign bus.nvm_req   = fetching;
    assign bus.busy      = fetching || (state_reg == CHECK);
    assign bus.key       = key_reg;
    assign bus.key_valid = (state_reg == VALID);
    assign bus.key_error = (state_reg == ERROR);

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader (KEY_WIDTH=2, TIMEOUT=16): directed table,
// multi-cycle corner sequences and randomized loads against a cycle-count reference model.
module tb_key_loader;
    localparam int KW = 2;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    key_loader_if #(.KEY_WIDTH(KW)) bus ();

    key_loader #(
        .KEY_WIDTH(KW),
        .TIMEOUT  (TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int failures = 0;

    typedef struct {
        logic [KW-1:0] data;
        logic          par;
        int            g0;
        int            g1;
        int            g2;
        logic [KW-1:0] exp_key;
        logic          exp_valid;
        logic          exp_error;
        int            exp_cycle;
        int            exp_xfers;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %0s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: each bit i waits gaps[i] ack-low cycles then transfers in one cycle.
    // A wait of TIMEOUT cycles aborts; otherwise CHECK follows the parity transfer.
    task automatic model(input logic [KW-1:0] data, input logic par, input int gaps[3],
                         output logic [KW-1:0] k, output logic v, output logic e,
                         output int cyc, output int xf);
        int t;
        t  = 1;
        xf = KW + 1;
        for (int j = 0; j <= KW; j++) begin
            if (gaps[j] >= TO) begin
                k = '0; v = 1'b0; e = 1'b1; cyc = t + TO; xf = j;
                return;
            end
            t += gaps[j] + 1;
        end
        cyc = t + 1;
        if (((^data) ^ par) == 1'b0) begin
            k = data; v = 1'b1; e = 1'b0;
        end else begin
            k = '0; v = 1'b0; e = 1'b1;
        end
    endtask

    task automatic run_load(input string tag, input int idx,
                            input logic [KW-1:0] data, input logic par,
                            input int g0, input int g1, input int g2, input int restart_at,
                            input logic [KW-1:0] exp_key, input logic exp_valid,
                            input logic exp_error, input int exp_cycle, input int exp_xfers);
        int   gaps[3];
        int   j;
        int   g;
        int   c;
        int   done_c;
        int   xfers;
        logic busy_ok;
        logic hold_ok;
        gaps    = '{g0, g1, g2};
        j       = 0;
        done_c  = -1;
        xfers   = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;

        bus.load_start = 1'b1;
        bus.nvm_ack    = 1'($urandom_range(0, 1));
        bus.nvm_bit    = 1'($urandom_range(0, 1));
        tick();
        c = 1;
        bus.load_start = 1'b0;
        g = gaps[0];
        while (done_c < 0 && c < 200) begin
            if (j <= KW) begin
                if (g > 0) begin
                    bus.nvm_ack = 1'b0;
                    bus.nvm_bit = 1'($urandom_range(0, 1));
                    g--;
                end else begin
                    bus.nvm_ack = 1'b1;
                    bus.nvm_bit = (j < KW) ? data[j] : par;
                    j++;
                    if (j <= KW) g = gaps[j];
                end
            end else begin
                bus.nvm_ack = 1'($urandom_range(0, 1));
                bus.nvm_bit = 1'($urandom_range(0, 1));
            end
            if (c == restart_at) bus.load_start = 1'b1;
            if (bus.nvm_req && bus.nvm_ack) xfers++;
            if (!bus.busy || bus.key != '0 || bus.key_valid || bus.key_error) busy_ok = 1'b0;
            tick();
            c++;
            bus.load_start = 1'b0;
            if (bus.key_valid || bus.key_error) done_c = c;
        end

        check($sformatf("%0s%0d_cycle", tag, idx), done_c, exp_cycle);
        check($sformatf("%0s%0d_key", tag, idx), int'(bus.key), int'(exp_key));
        check($sformatf("%0s%0d_valid", tag, idx), int'(bus.key_valid), int'(exp_valid));
        check($sformatf("%0s%0d_error", tag, idx), int'(bus.key_error), int'(exp_error));
        check($sformatf("%0s%0d_idle", tag, idx), int'({bus.busy, bus.nvm_req}), 0);
        check($sformatf("%0s%0d_xfers", tag, idx), xfers, exp_xfers);
        check($sformatf("%0s%0d_busy_window", tag, idx), int'(busy_ok), 1);

        // Result must hold while storage keeps toggling ack with no request.
        for (int h = 0; h < 2; h++) begin
            bus.nvm_ack = 1'($urandom_range(0, 1));
            bus.nvm_bit = 1'($urandom_range(0, 1));
            tick();
            if (bus.key != exp_key || bus.key_valid != exp_valid ||
                bus.key_error != exp_error || bus.busy || bus.nvm_req) hold_ok = 1'b0;
        end
        check($sformatf("%0s%0d_hold", tag, idx), int'(hold_ok), 1);
        bus.nvm_ack = 1'b0;

        $display("[TB] load %0s%0d data=%b par=%b gaps=%0d/%0d/%0d -> key=%b valid=%b error=%b cycle=%0d xfers=%0d",
                 tag, idx, data, par, g0, g1, g2, bus.key, bus.key_valid, bus.key_error, done_c, xfers);
    endtask

    initial begin
        logic [KW-1:0] r_data;
        logic          r_par;
        int            r_gaps[3];
        logic [KW-1:0] m_key;
        logic          m_valid;
        logic          m_error;
        int            m_cycle;
        int            m_xfers;

        vecs[0] = '{2'b01, 1'b1,  0, 0,  0, 2'b01, 1'b1, 1'b0,  5, 3};
        vecs[1] = '{2'b11, 1'b1,  0, 0,  0, 2'b00, 1'b0, 1'b1,  5, 3};
        vecs[2] = '{2'b01, 1'b1,  0, 5,  0, 2'b01, 1'b1, 1'b0, 10, 3};
        vecs[3] = '{2'b00, 1'b0,  0, 0,  0, 2'b00, 1'b1, 1'b0,  5, 3};
        vecs[4] = '{2'b10, 1'b1,  2, 0,  3, 2'b10, 1'b1, 1'b0, 10, 3};
        vecs[5] = '{2'b01, 1'b1, 16, 0,  0, 2'b00, 1'b0, 1'b1, 17, 0};
        vecs[6] = '{2'b11, 1'b0, 15, 0,  0, 2'b11, 1'b1, 1'b0, 20, 3};
        vecs[7] = '{2'b01, 1'b1,  0, 0, 16, 2'b00, 1'b0, 1'b1, 19, 2};
        vecs[8] = '{2'b11, 1'b0,  0, 0, 15, 2'b11, 1'b1, 1'b0, 20, 3};

        bus.load_start = 1'b0;
        bus.nvm_ack    = 1'b1;
        bus.nvm_bit    = 1'b1;
        rst            = 1'b1;
        tick();
        tick();
        check("reset_outputs",
              int'({bus.key, bus.key_valid, bus.key_error, bus.busy, bus.nvm_req}), 0);
        rst = 1'b0;
        tick();
        check("idle_ignores_ack", int'({bus.busy, bus.nvm_req, bus.key_valid}), 0);
        bus.nvm_ack = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_load("vec", i, vecs[i].data, vecs[i].par, vecs[i].g0, vecs[i].g1, vecs[i].g2, -1,
                     vecs[i].exp_key, vecs[i].exp_valid, vecs[i].exp_error,
                     vecs[i].exp_cycle, vecs[i].exp_xfers);
        end

        // Reset right after the first transfer discards the load.
        bus.load_start = 1'b1;
        bus.nvm_ack    = 1'b1;
        bus.nvm_bit    = 1'b1;
        tick();
        bus.load_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.nvm_ack = 1'b0;
        check("midload_reset_req", int'(bus.nvm_req), 0);
        check("midload_reset_busy", int'(bus.busy), 0);
        check("midload_reset_key", int'({bus.key, bus.key_valid, bus.key_error}), 0);
        $display("[TB] load midload_reset req=%b busy=%b key=%b", bus.nvm_req, bus.busy, bus.key);
        run_load("after_reset", 0, 2'b01, 1'b1, 0, 0, 0, -1, 2'b01, 1'b1, 1'b0, 5, 3);

        // Reset wins over load_start on the same edge.
        rst            = 1'b1;
        bus.load_start = 1'b1;
        tick();
        rst            = 1'b0;
        bus.load_start = 1'b0;
        tick();
        check("rst_over_start", int'({bus.busy, bus.nvm_req, bus.key_valid, bus.key}), 0);
        $display("[TB] load rst_over_start busy=%b req=%b", bus.busy, bus.nvm_req);

        // load_start during FETCH is ignored.
        run_load("restart", 0, 2'b01, 1'b1, 0, 2, 0, 2, 2'b01, 1'b1, 1'b0, 7, 3);
        run_load("restart", 1, 2'b10, 1'b1, 1, 0, 1, 3, 2'b10, 1'b1, 1'b0, 7, 3);

        for (int n = 0; n < 30; n++) begin
            r_data = KW'($urandom_range(0, 3));
            r_par  = 1'($urandom_range(0, 1));
            for (int k = 0; k <= KW; k++) begin
                if ($urandom_range(0, 9) < 8) r_gaps[k] = int'($urandom_range(0, 3));
                else                          r_gaps[k] = int'($urandom_range(14, 17));
            end
            model(r_data, r_par, r_gaps, m_key, m_valid, m_error, m_cycle, m_xfers);
            run_load("rand", n, r_data, r_par, r_gaps[0], r_gaps[1], r_gaps[2], -1,
                     m_key, m_valid, m_error, m_cycle, m_xfers);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
